ringosc_freq_meter: RTL

Gated frequency meter that consumes the free-running output of the 5-inverter ring oscillator and measures it against the system clock. The ring output is prescaled in its own domain, synchronised into `clk`, and its transitions are counted over a programmable gate window. The result is latched and presented byte-wise on an 8-bit output bus for the TinyTapeout `uo_out` pins.

---
 rtl/ringosc_meas_pkg.sv | 27 ++
 rtl/ro_prescale_sync.sv | 35 +++
 rtl/ringosc_freq_meter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ringosc_meas_pkg.sv
// Shared types and constants for the ring-oscillator frequency meter.
package ringosc_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } meas_state_t;

  localparam int GATE_BASE_LOG2 = 8;

  localparam logic [1:0] SEL_RES_LO = 2'd0;
  localparam logic [1:0] SEL_RES_HI = 2'd1;
  localparam logic [1:0] SEL_STATUS = 2'd2;
  localparam logic [1:0] SEL_ID     = 2'd3;

  localparam logic [7:0] METER_ID = 8'h5A;

  // Terminal value of the window counter: window length minus one.
  function automatic logic [15:0] gate_last(input logic [2:0] g);
    logic [15:0] one;
    one = 16'd1;
    return (one << (4'(GATE_BASE_LOG2) + {1'b0, g})) - 16'd1;
  endfunction

endpackage

// File: rtl/ro_prescale_sync.sv
// Ring-domain prescaler plus clk-domain synchroniser; emits one event pulse
// per change of the prescaler MSB. The only logic clocked by ro_in.
module ro_prescale_sync #(
  parameter int PRESCALE_BITS = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ro_in,
  output logic evt
);

  logic [PRESCALE_BITS-1:0] div_q;
  logic [SYNC_STAGES-1:0]   sync_p;
  logic                     hist_p;

  always_ff @(posedge ro_in or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_q + 1'b1;
  end

  // ro_in -> clk crossing; the history flop turns level changes into pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= '0;
      hist_p <= 1'b0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], div_q[PRESCALE_BITS-1]};
      hist_p <= sync_p[SYNC_STAGES-1];
    end
  end

  assign evt = sync_p[SYNC_STAGES-1] ^ hist_p;

endmodule

// File: rtl/ringosc_freq_meter.sv
// Gated ring-oscillator frequency meter with byte-wise result readout.
// Define RINGOSC_MEAS_AUTORESTART_EN for continuous back-to-back measurement.
import ringosc_meas_pkg::*;

module ringosc_freq_meter #(
  parameter int PRESCALE_BITS = 4,
  parameter int CNT_W         = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       ro_in,
  input  logic       start,
  input  logic [2:0] gate_sel,
  input  logic [1:0] byte_sel,
  output logic [7:0] meas_out,
  output logic       busy,
  output logic       valid,
  output logic       overflow
);

  meas_state_t      state;
  logic             evt;
  logic             start_req;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] result;
  logic [15:0]      res_ext;
  logic [15:0]      win_cnt;
  logic [2:0]       gsel_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ro_prescale_sync #(
    .PRESCALE_BITS(PRESCALE_BITS),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_prescale_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .ro_in(ro_in),
    .evt  (evt)
  );

`ifdef RINGOSC_MEAS_AUTORESTART_EN
  assign start_req = 1'b1;
`else
  assign start_req = start;
`endif

  assign cnt_next = evt ? sat_inc(cnt_q) : cnt_q;

  // The result is captured on the edge that closes the window, so it is
  // already visible (with valid) during the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      result   <= '0;
      gsel_q   <= 3'd0;
      cnt_q    <= '0;
      win_cnt  <= 16'd0;
    end else if (!ena) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            state <= ST_ARM;
            busy  <= 1'b1;
          end
        end
        ST_ARM: begin
          gsel_q  <= gate_sel;
          cnt_q   <= '0;
          win_cnt <= 16'd0;
`ifndef RINGOSC_MEAS_AUTORESTART_EN
          valid    <= 1'b0;
          overflow <= 1'b0;
`endif
          state <= ST_COUNT;
        end
        ST_COUNT: begin
          cnt_q <= cnt_next;
          if (win_cnt == gate_last(gsel_q)) begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            valid    <= 1'b1;
            result   <= cnt_next;
            overflow <= &cnt_next;
          end else begin
            win_cnt <= win_cnt + 16'd1;
          end
        end
        ST_DONE: begin
`ifdef RINGOSC_MEAS_AUTORESTART_EN
          state <= ST_ARM;
          busy  <= 1'b1;
`else
          state <= ST_IDLE;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign res_ext = 16'(result);

  always_comb begin
    meas_out = 8'h00;
    case (byte_sel)
      SEL_RES_LO: meas_out = res_ext[7:0];
      SEL_RES_HI: meas_out = res_ext[15:8];
      SEL_STATUS: meas_out = {overflow, valid, busy, 2'b00, gsel_q};
      default:    meas_out = METER_ID;
    endcase
  end

endmodule
